// File: rtl/control_pkg.sv
// control_pkg: shared types and decode tables for the control sequencer.
//   - state_t      : sequencer states IDLE, T0..T6, HALT
//   - op_class_t   : execution class of an opcode
//   - OP_*         : opcode constants, ALU_* : ALU operation codes
//   - decode_class / decode_alu_op : opcode -> class / ALU op code
// Optional feature macro: CONTROL_SEQUENCER_MULDIV_EN (MUL/DIV legal when defined).
package control_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU, CLS_MULDIV, CLS_NOP, CLS_HALT, CLS_ILLEGAL
    } op_class_t;

    // IR field positions
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RA_HI  = 26;
    localparam int RA_LO  = 23;
    localparam int RB_HI  = 22;
    localparam int RB_LO  = 19;
    localparam int RC_HI  = 18;
    localparam int RC_LO  = 15;

    // Opcodes
    localparam logic [4:0] OP_ADD  = 5'b01001;
    localparam logic [4:0] OP_SUB  = 5'b01010;
    localparam logic [4:0] OP_AND  = 5'b01011;
    localparam logic [4:0] OP_OR   = 5'b01100;
    localparam logic [4:0] OP_SHR  = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NOP  = 5'b11000;
    localparam logic [4:0] OP_HALT = 5'b11001;

    // ALU operation codes presented on ALU_op during T4
    localparam logic [4:0] ALU_NONE = 5'b00000;
    localparam logic [4:0] ALU_ADD  = 5'b00011;
    localparam logic [4:0] ALU_SUB  = 5'b00100;
    localparam logic [4:0] ALU_AND  = 5'b00101;
    localparam logic [4:0] ALU_OR   = 5'b00110;
    localparam logic [4:0] ALU_SHR  = 5'b00111;
    localparam logic [4:0] ALU_MUL  = 5'b01000;
    localparam logic [4:0] ALU_DIV  = 5'b01001;

    function automatic op_class_t decode_class(input logic [4:0] opc);
        op_class_t cls;
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR: cls = CLS_ALU;
`ifdef CONTROL_SEQUENCER_MULDIV_EN
            OP_MUL, OP_DIV:                        cls = CLS_MULDIV;
`endif
            OP_NOP:                                cls = CLS_NOP;
            OP_HALT:                               cls = CLS_HALT;
            default:                               cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

    function automatic logic [4:0] decode_alu_op(input logic [4:0] opc);
        logic [4:0] op;
        case (opc)
            OP_ADD:  op = ALU_ADD;
            OP_SUB:  op = ALU_SUB;
            OP_AND:  op = ALU_AND;
            OP_OR:   op = ALU_OR;
            OP_SHR:  op = ALU_SHR;
            OP_MUL:  op = ALU_MUL;
            OP_DIV:  op = ALU_DIV;
            default: op = ALU_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/control_decode.sv
// control_decode: combinational opcode decoder.
//   opcode  in  5  IR[31:27]
//   op_class out   execution class (ALU, MUL/DIV, NOP, HALT, illegal)
//   alu_op  out 5  ALU operation code for T4
//   illegal out 1  opcode not executable in this build
// MUL/DIV legality follows CONTROL_SEQUENCER_MULDIV_EN.
module control_decode
    import control_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_t  op_class,
    output logic [4:0] alu_op,
    output logic       illegal
);

    assign op_class = decode_class(opcode);
    assign alu_op   = decode_alu_op(opcode);
    assign illegal  = (op_class == CLS_ILLEGAL);

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: Moore control unit for the single-bus datapath.
// Fetch T0-T2, execute T3-T6, counts retired instructions.
//   Clock, Clear(async, active high), Run, MemReady, IR[31:0]  inputs
//   bus drive strobes  : PCout Zlowout ZHighout MDRout Rout
//   load strobes       : MARin PCin MDRin IRin Yin Rin ZLowIn ZHighIn HIin LOin
//   misc               : IncPC Read ALU_op[4:0] Gra Grb Grc
//   status             : Halted IllegalOp InstrCount[CNT_W-1:0]
// Macro CONTROL_SEQUENCER_MULDIV_EN enables MUL/DIV (T6, ZHighIn/ZHighout/HIin/LOin).
module control_sequencer
    import control_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic             Clock,
    input  logic             Clear,
    input  logic             Run,
    input  logic             MemReady,
    input  logic [31:0]      IR,
    output logic             PCout,
    output logic             Zlowout,
    output logic             ZHighout,
    output logic             MDRout,
    output logic             Rout,
    output logic             MARin,
    output logic             PCin,
    output logic             MDRin,
    output logic             IRin,
    output logic             Yin,
    output logic             Rin,
    output logic             ZLowIn,
    output logic             ZHighIn,
    output logic             HIin,
    output logic             LOin,
    output logic             IncPC,
    output logic             Read,
    output logic [4:0]       ALU_op,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             Halted,
    output logic             IllegalOp,
    output logic [CNT_W-1:0] InstrCount
);

    state_t           state_reg, state_next;
    logic             t1_first_reg;
    logic             illegal_reg;
    logic [CNT_W-1:0] count_reg;
    logic             retire;

    op_class_t        dec_class;
    logic [4:0]       dec_alu_op;
    logic             dec_illegal;

    // Register fields are consumed by the datapath's register encoder, not here.
    logic ir_fields_unused;
    assign ir_fields_unused = ^IR[RA_HI:0];

    control_decode u_decode (
        .opcode   (IR[OPC_HI:OPC_LO]),
        .op_class (dec_class),
        .alu_op   (dec_alu_op),
        .illegal  (dec_illegal)
    );

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state_reg    <= S_IDLE;
            t1_first_reg <= 1'b0;
            illegal_reg  <= 1'b0;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            // T1 is only entered from T0, so this marks the first T1 cycle.
            t1_first_reg <= (state_reg == S_T0);
            if (state_reg == S_T3 && dec_illegal)
                illegal_reg <= 1'b1;
            if (retire)
                count_reg <= count_reg + CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state_reg;
        retire     = 1'b0;
        PCout = 1'b0; Zlowout = 1'b0; ZHighout = 1'b0; MDRout = 1'b0; Rout = 1'b0;
        MARin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0; Rin = 1'b0;
        ZLowIn = 1'b0; ZHighIn = 1'b0; HIin = 1'b0; LOin = 1'b0;
        IncPC = 1'b0; Read = 1'b0; ALU_op = ALU_NONE;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (Run)
                    state_next = S_T0;
            end
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1;
                state_next = S_T1;
            end
            S_T1: begin
                // Incremented PC is loaded once; Read/MDRin hold through the stall.
                Zlowout = 1'b1; Read = 1'b1; MDRin = 1'b1;
                PCin    = t1_first_reg;
                if (MemReady)
                    state_next = S_T2;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                state_next = S_T3;
            end
            S_T3: begin
                case (dec_class)
                    CLS_ALU, CLS_MULDIV: begin
                        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                        state_next = S_T4;
                    end
                    CLS_NOP: retire     = 1'b1;
                    default: state_next = S_HALT;
                endcase
            end
            S_T4: begin
                Grc = 1'b1; Rout = 1'b1; ZLowIn = 1'b1;
                ALU_op = dec_alu_op;
`ifdef CONTROL_SEQUENCER_MULDIV_EN
                ZHighIn = (dec_class == CLS_MULDIV);
`endif
                state_next = S_T5;
            end
            S_T5: begin
                Zlowout = 1'b1;
`ifdef CONTROL_SEQUENCER_MULDIV_EN
                if (dec_class == CLS_MULDIV) begin
                    LOin = 1'b1;
                    state_next = S_T6;
                end else begin
                    Gra = 1'b1; Rin = 1'b1;
                    retire = 1'b1;
                end
`else
                Gra = 1'b1; Rin = 1'b1;
                retire = 1'b1;
`endif
            end
`ifdef CONTROL_SEQUENCER_MULDIV_EN
            S_T6: begin
                ZHighout = 1'b1; HIin = 1'b1;
                retire = 1'b1;
            end
`endif
            S_HALT: state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase

        // Run is only consulted here and in IDLE, so a mid-instruction drop finishes the instruction.
        if (retire)
            state_next = Run ? S_T0 : S_IDLE;
    end

    assign Halted     = (state_reg == S_HALT);
    assign IllegalOp  = illegal_reg;
    assign InstrCount = count_reg;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: scoreboard bench for control_sequencer.
// Stimulus pushes the expected per-cycle control word; a negedge monitor pops and compares.
// A second instance with a 3-bit counter runs in parallel to exercise counter wrap.
// Honors CONTROL_SEQUENCER_MULDIV_EN for the MUL scenario.
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        Clear = 1'b1;
    logic        Run = 1'b0;
    logic        MemReady = 1'b0;
    logic [31:0] IR = '0;

    wire [19:0]  str;
    wire [4:0]   ALU_op;
    wire         Halted, IllegalOp;
    wire [15:0]  InstrCount;

    wire [19:0]  s_str;
    wire [4:0]   s_alu;
    wire         s_halted, s_illegal;
    wire [2:0]   s_count;

    localparam logic [19:0] PCOUT   = 20'h80000, ZLOWOUT = 20'h40000, ZHIGHOUT = 20'h20000;
    localparam logic [19:0] MDROUT  = 20'h10000, ROUT    = 20'h08000, MARIN    = 20'h04000;
    localparam logic [19:0] PCIN    = 20'h02000, MDRIN   = 20'h01000, IRIN     = 20'h00800;
    localparam logic [19:0] YIN     = 20'h00400, RIN     = 20'h00200, ZLOWIN   = 20'h00100;
    localparam logic [19:0] ZHIGHIN = 20'h00080, HIIN    = 20'h00040, LOIN     = 20'h00020;
    localparam logic [19:0] INCPC   = 20'h00010, READ    = 20'h00008, GRA      = 20'h00004;
    localparam logic [19:0] GRB     = 20'h00002, GRC     = 20'h00001;

    localparam logic [19:0] E_T0  = PCOUT | MARIN | INCPC | ZLOWIN;
    localparam logic [19:0] E_T1F = ZLOWOUT | PCIN | READ | MDRIN;
    localparam logic [19:0] E_T1  = ZLOWOUT | READ | MDRIN;
    localparam logic [19:0] E_T2  = MDROUT | IRIN;
    localparam logic [19:0] E_T3  = GRB | ROUT | YIN;
    localparam logic [19:0] E_T4  = GRC | ROUT | ZLOWIN;
    localparam logic [19:0] E_T5  = ZLOWOUT | GRA | RIN;
    localparam logic [19:0] NONE  = 20'h00000;

    always #5 Clock = ~Clock;

    control_sequencer #(.CNT_W(16)) dut (
        .Clock(Clock), .Clear(Clear), .Run(Run), .MemReady(MemReady), .IR(IR),
        .PCout(str[19]), .Zlowout(str[18]), .ZHighout(str[17]), .MDRout(str[16]), .Rout(str[15]),
        .MARin(str[14]), .PCin(str[13]), .MDRin(str[12]), .IRin(str[11]), .Yin(str[10]),
        .Rin(str[9]), .ZLowIn(str[8]), .ZHighIn(str[7]), .HIin(str[6]), .LOin(str[5]),
        .IncPC(str[4]), .Read(str[3]), .ALU_op(ALU_op), .Gra(str[2]), .Grb(str[1]), .Grc(str[0]),
        .Halted(Halted), .IllegalOp(IllegalOp), .InstrCount(InstrCount)
    );

    control_sequencer #(.CNT_W(3)) dut_small (
        .Clock(Clock), .Clear(Clear), .Run(Run), .MemReady(MemReady), .IR(IR),
        .PCout(s_str[19]), .Zlowout(s_str[18]), .ZHighout(s_str[17]), .MDRout(s_str[16]), .Rout(s_str[15]),
        .MARin(s_str[14]), .PCin(s_str[13]), .MDRin(s_str[12]), .IRin(s_str[11]), .Yin(s_str[10]),
        .Rin(s_str[9]), .ZLowIn(s_str[8]), .ZHighIn(s_str[7]), .HIin(s_str[6]), .LOin(s_str[5]),
        .IncPC(s_str[4]), .Read(s_str[3]), .ALU_op(s_alu), .Gra(s_str[2]), .Grb(s_str[1]), .Grc(s_str[0]),
        .Halted(s_halted), .IllegalOp(s_illegal), .InstrCount(s_count)
    );

    typedef struct {
        string       name;
        logic [19:0] str;
        logic [4:0]  alu;
        logic        halted;
        logic        illegal;
        logic [15:0] count;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] exp_count = '0;

    // One scoreboard entry per clock cycle: the control word the DUT must present.
    task automatic cyc(input string name, input logic [19:0] s, input logic [4:0] a = 5'd0,
                       input logic h = 1'b0, input logic il = 1'b0);
        exp_t e;
        e.name = name; e.str = s; e.alu = a; e.halted = h; e.illegal = il; e.count = exp_count;
        sb_q.push_back(e);
        @(posedge Clock);
        #1;
    endtask

    always @(negedge Clock) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_checks++;
            if ({str, ALU_op, Halted, IllegalOp, InstrCount} !== {e.str, e.alu, e.halted, e.illegal, e.count}) begin
                n_fail++;
                $display("FAIL %s: got str=%05h alu=%02h halt=%b ill=%b cnt=%0d, expected str=%05h alu=%02h halt=%b ill=%b cnt=%0d",
                         e.name, str, ALU_op, Halted, IllegalOp, InstrCount,
                         e.str, e.alu, e.halted, e.illegal, e.count);
            end else begin
                $display("%0t ok %s str=%05h alu=%02h halt=%b ill=%b cnt=%0d",
                         $time, e.name, str, ALU_op, Halted, IllegalOp, InstrCount);
            end
            n_checks++;
            if (s_count !== e.count[2:0]) begin
                n_fail++;
                $display("FAIL %s_wrap: got cnt3=%0d, expected cnt3=%0d", e.name, s_count, e.count[2:0]);
            end
        end
    end

    initial begin
        repeat (2) @(posedge Clock);
        #1;
        // Reset and idle
        cyc("reset", NONE);
        Clear = 1'b0;
        for (int i = 0; i < 10; i++) cyc("idle", NONE);

        // ADD, no memory stall: T0..T5 in 6 cycles
        IR = 32'h4A920000; MemReady = 1'b1; Run = 1'b1;
        cyc("add_idle", NONE);
        cyc("add_t0", E_T0);
        Run = 1'b0;
        cyc("add_t1", E_T1F);
        cyc("add_t2", E_T2);
        cyc("add_t3", E_T3);
        cyc("add_t4", E_T4, 5'b00011);
        cyc("add_t5", E_T5);
        exp_count = exp_count + 16'd1;
        cyc("add_done", NONE);

        // ADD with 3 stall cycles in T1: 9 cycles total
        Run = 1'b1; MemReady = 1'b0;
        cyc("stl_idle", NONE);
        cyc("stl_t0", E_T0);
        Run = 1'b0;
        cyc("stl_t1a", E_T1F);
        cyc("stl_t1b", E_T1);
        cyc("stl_t1c", E_T1);
        MemReady = 1'b1;
        cyc("stl_t1d", E_T1);
        cyc("stl_t2", E_T2);
        cyc("stl_t3", E_T3);
        cyc("stl_t4", E_T4, 5'b00011);
        cyc("stl_t5", E_T5);
        exp_count = exp_count + 16'd1;
        cyc("stl_done", NONE);

        // Nine back-to-back NOPs (4 cycles each); wraps the 3-bit counter
        IR = 32'hC0000000; Run = 1'b1;
        cyc("nop_idle", NONE);
        for (int k = 0; k < 9; k++) begin
            cyc("nop_t0", E_T0);
            if (k == 8) Run = 1'b0;
            cyc("nop_t1", E_T1F);
            cyc("nop_t2", E_T2);
            cyc("nop_t3", NONE);
            exp_count = exp_count + 16'd1;
        end
        cyc("nop_done", NONE);

        // Clear during T4 aborts, then Run restarts at T0
        IR = 32'h4A920000; Run = 1'b1;
        cyc("clr_idle0", NONE);
        cyc("clr_t0a", E_T0);
        cyc("clr_t1a", E_T1F);
        cyc("clr_t2a", E_T2);
        cyc("clr_t3a", E_T3);
        Clear = 1'b1; exp_count = '0;
        cyc("clr_t4", NONE);
        Clear = 1'b0;
        cyc("clr_idle1", NONE);
        cyc("clr_t0", E_T0);
        Run = 1'b0;
        cyc("clr_t1", E_T1F);
        cyc("clr_t2", E_T2);
        cyc("clr_t3", E_T3);
        cyc("clr_t4b", E_T4, 5'b00011);
        cyc("clr_t5", E_T5);
        exp_count = exp_count + 16'd1;
        cyc("clr_done", NONE);

        // MUL
        IR = 32'h70920000; Run = 1'b1;
        cyc("mul_idle", NONE);
        cyc("mul_t0", E_T0);
        Run = 1'b0;
        cyc("mul_t1", E_T1F);
        cyc("mul_t2", E_T2);
`ifdef CONTROL_SEQUENCER_MULDIV_EN
        cyc("mul_t3", E_T3);
        cyc("mul_t4", E_T4 | ZHIGHIN, 5'b01000);
        cyc("mul_t5", ZLOWOUT | LOIN);
        cyc("mul_t6", ZHIGHOUT | HIIN);
        exp_count = exp_count + 16'd1;
        cyc("mul_done", NONE);
`else
        Run = 1'b1;
        cyc("mul_t3", NONE);
        cyc("mul_halt", NONE, 5'd0, 1'b1, 1'b1);
        cyc("mul_halt", NONE, 5'd0, 1'b1, 1'b1);
        Clear = 1'b1; exp_count = '0;
        cyc("mul_clr", NONE);
        Clear = 1'b0; Run = 1'b0;
        cyc("mul_idle2", NONE);
`endif

        // Unlisted opcode 5'b11111 -> illegal, halt with Run held high
        IR = 32'hF8000000; Run = 1'b1;
        cyc("ill_idle", NONE);
        cyc("ill_t0", E_T0);
        cyc("ill_t1", E_T1F);
        cyc("ill_t2", E_T2);
        cyc("ill_t3", NONE);
        for (int i = 0; i < 3; i++) cyc("ill_halt", NONE, 5'd0, 1'b1, 1'b1);
        Clear = 1'b1; exp_count = '0;
        cyc("ill_clr", NONE);
        Clear = 1'b0; Run = 1'b0;
        cyc("ill_idle1", NONE);
        cyc("ill_idle2", NONE);

        @(negedge Clock);
        #1;
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending entries, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit that drives the single-bus datapath through fetch (T0–T2) and execute (T3–T6) for each instruction. It replaces hand-sequenced bench stimulus with a Moore FSM that asserts the datapath's out/in strobes, ALU op code and register-select lines, and counts retired instructions. It sits beside the datapath and connects to its control pins and the IR contents.

## Interface
- CNT_W, 16, width of retired-instruction counter
- Clock  in  1  rising-edge clock for all state
- Clear  in  1  asynchronous, active-high reset
- Run  in  1  level; permits leaving IDLE and starting the next fetch
- MemReady  in  1  memory has Mdatain valid this cycle
- IR  in  32  instruction register contents; opcode IR[31:27], ra IR[26:23], rb IR[22:19], rc IR[18:15]
- PCout, Zlowout, ZHighout, MDRout, Rout  out  1  bus drive strobes
- MARin, PCin, MDRin, IRin, Yin, Rin, ZLowIn, ZHighIn, HIin, LOin  out  1  register load strobes
- IncPC, Read  out  1  PC increment select; memory read request
- ALU_op  out  5  ALU operation code
- Gra, Grb, Grc  out  1  one-hot field select for register encoder
- Halted, IllegalOp  out  1  sticky status flags
- InstrCount  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT. All outputs are decoded from the registered state and IR only (Moore); a strobe is asserted for the full cycle and the datapath captures it on the next rising edge.
- IDLE: all strobes 0. Go to T0 when Run=1.
- T0: PCout, MARin, IncPC, ZLowIn → T1.
- T1: Zlowout, PCin, Read, MDRin. Stay in T1 while MemReady=0; PCin asserted only in the first T1 cycle. Read/MDRin held until MemReady=1 → T2.
- T2: MDRout, IRin → T3 (IR sampled from T3 onward).
- T3 decode: ALU class → Grb, Rout, Yin → T4. NOP → retire. HALT opcode → HALT. Unlisted opcode → IllegalOp=1, HALT.
- T4: Grc, Rout, ALU_op=decode(opcode), ZLowIn; MUL/DIV also ZHighIn → T5.
- T5: ALU class: Zlowout, Gra, Rin → retire. MUL/DIV: Zlowout, LOin → T6.
- T6: ZHighout, HIin → retire.
- Retire: InstrCount+1; next state T0 if Run=1 else IDLE.
- HALT: Halted=1, all strobes 0; exits only on Clear.
- Opcode 5'b01001 (ADD) maps to ALU_op 5'b00011; full table lives in the package.

## Timing
- Reset: state IDLE, every output 0, InstrCount 0, flags 0. Clear mid-instruction aborts immediately; no partial strobes persist after Clear rises.
- ALU instruction with MemReady already high: T0–T5 = 6 cycles; MUL/DIV 7; NOP 4. Each MemReady=0 cycle in T1 adds one.
- Run sampled only in IDLE and at retire; dropping Run mid-instruction finishes the instruction.
- InstrCount increments on the retire edge; 0xFFFF → 0x0000.
- Never two bus drivers in one state; never Rin and Rout together.

## Configuration
- CONTROL_SEQUENCER_MULDIV_EN: defined → MUL (5'b01110) and DIV (5'b01111) execute via T4–T6 with ZHighIn/HIin/LOin. Undefined → those opcodes are illegal (IllegalOp, HALT), T6 does not exist, ZHighIn/ZHighout/HIin/LOin tied 0.

## Structure
- Package control_pkg: state enum, opcode constants, opcode→ALU_op table, opcode class decode function, field bit positions.
- One sub-module: control_decode (combinational opcode → class, ALU_op, illegal).
- Top holds state register, counter and output decode.

## Test plan
- Clear high then low, Run=0 → IDLE for 10 cycles, all outputs 0, InstrCount=0.
- Run=1, MemReady=1, IR=0x4A920000 → T0..T5 in 6 cycles; T3 Grb+Rout+Yin, T4 Grc+Rout+ALU_op=5'b00011+ZLowIn, T5 Gra+Rin+Zlowout; InstrCount=1.
- Same, MemReady low 3 cycles in T1 → Read/MDRin held 4 cycles, PCin pulses once, total 9 cycles.
- IR opcode 5'b11111 → IllegalOp=1, Halted=1, strobes 0 while Run stays 1; Clear recovers to IDLE.
- MUL with CONTROL_SEQUENCER_MULDIV_EN → T5 LOin, T6 HIin, 7 cycles; without macro → IllegalOp.
- Clear asserted during T4 → same cycle all strobes 0, InstrCount 0; Run then restarts at T0.
